// File: rtl/sevenseg_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with blink, brightness PWM and guard interval.
// Optional leading-zero blanking is compiled in when SEVSEG_LZB_EN is defined.
module sevenseg_scanner #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 200000,
    parameter int GUARD        = 2000,
    parameter int BRIGHT_W     = 3,
    parameter int BLINK_FRAMES = 83
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   enable_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [6:0]              seg,
    output logic                    decimal,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SLOT_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int LIM_W   = BRIGHT_W + 34;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(NUM_DIGITS - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);
    localparam logic [LIM_W-1:0]   GUARD_L    = LIM_W'(GUARD);
    localparam logic [LIM_W-1:0]   SPAN_L     = LIM_W'(SCAN_DIV - GUARD);

    logic [SCAN_W-1:0]  scan_cnt;
    logic [SLOT_W-1:0]  slot;
    logic [FRAME_W-1:0] frame_cnt;
    logic               blink_dark;

    logic [3:0] nib_p0;
    logic       dp_p0;
    logic       en_p0;
    logic       blink_p0;

    logic [3:0] live_nib;
    logic       live_dp;
    logic       live_en;
    logic       live_blink;

    logic [3:0] cur_nib;
    logic       cur_dp;
    logic       cur_en;
    logic       cur_blink;

    logic [LIM_W-1:0] on_limit;
    logic             in_window;
    logic             lit;
    logic             slot_end;
    logic             frame_end;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign live_nib   = digits[4*int'(slot) +: 4];
    assign live_dp    = dp[slot];
    assign live_blink = blink_mask[slot];

`ifdef SEVSEG_LZB_EN
    // A digit is a leading zero while it and every higher digit are zero without a dp.
    function automatic logic lzb_blank(input logic [4*NUM_DIGITS-1:0] d,
                                       input logic [NUM_DIGITS-1:0]   p,
                                       input logic [SLOT_W-1:0]       s);
        logic leading;
        logic blank;
        leading = 1'b1;
        blank   = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (d[4*i +: 4] != 4'h0 || p[i]) leading = 1'b0;
            if (i == int'(s)) blank = leading;
        end
        return blank;
    endfunction

    assign live_en = enable_mask[slot] & ~lzb_blank(digits, dp, slot);
`else
    assign live_en = enable_mask[slot];
`endif

    // Slot attributes come straight from the inputs on the latch cycle, then from the p0 copy.
    always_comb begin
        cur_nib   = nib_p0;
        cur_dp    = dp_p0;
        cur_en    = en_p0;
        cur_blink = blink_p0;
        if (scan_cnt == '0) begin
            cur_nib   = live_nib;
            cur_dp    = live_dp;
            cur_en    = live_en;
            cur_blink = live_blink;
        end
    end

    assign on_limit  = GUARD_L + (((LIM_W'(brightness) + LIM_W'(1)) * SPAN_L) >> BRIGHT_W);
    assign in_window = (LIM_W'(scan_cnt) >= GUARD_L) && (LIM_W'(scan_cnt) < on_limit);
    assign lit       = in_window && cur_en && !(cur_blink && blink_dark);
    assign slot_end  = (scan_cnt == SCAN_LAST);
    assign frame_end = slot_end && (slot == SLOT_LAST);

    // Stage p0: per-slot attribute latch.
    always_ff @(posedge clk) begin
        if (scan_cnt == '0) begin
            nib_p0   <= live_nib;
            dp_p0    <= live_dp;
            en_p0    <= live_en;
            blink_p0 <= live_blink;
        end
    end

    // Stage p1: scan counters, blink phase and registered pin drive.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt   <= '0;
            slot       <= '0;
            frame_cnt  <= '0;
            blink_dark <= 1'b0;
            an         <= '1;
            seg        <= 7'h7F;
            decimal    <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            if (slot_end) begin
                scan_cnt <= '0;
                slot     <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end

            if (frame_end) begin
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt  <= '0;
                    blink_dark <= ~blink_dark;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end

            frame_tick <= frame_end;

            if (lit) begin
                an      <= ~(NUM_DIGITS'(1) << slot);
                seg     <= hex7(cur_nib);
                decimal <= ~cur_dp;
            end else begin
                an      <= '1;
                seg     <= 7'h7F;
                decimal <= 1'b1;
            end
        end
    end

endmodule
